// File: rtl/llc_bus_sequencer_pkg.sv
// rtl/llc_bus_sequencer_pkg.sv - shared bus operation, snoop and sequencer state types
package llc_bus_sequencer_pkg;

   typedef enum logic [2:0] {
      BUS_NOP        = 3'b000,
      BUS_READ       = 3'b001,
      BUS_WRITE      = 3'b010,
      BUS_INVALIDATE = 3'b011,
      BUS_RWIM       = 3'b100
   } bus_operation_e;

   typedef enum logic [1:0] {
      SNOOP_NOHIT = 2'b00,
      SNOOP_HIT   = 2'b01,
      SNOOP_HITM  = 2'b10
   } snoop_result_e;

   // Encoding 2'b11 is not a defined snoop response.
   localparam logic [1:0] SNOOP_RESERVED = 2'b11;

   typedef enum logic [1:0] {
      SEQ_IDLE       = 2'd0,
      SEQ_ISSUE      = 2'd1,
      SEQ_WAIT_SNOOP = 2'd2,
      SEQ_RESP       = 2'd3
   } bus_seq_state_e;

   // Only READ, WRITE, INVALIDATE and RWIM may be placed on the bus.
   function automatic logic is_legal_busop(input logic [2:0] op);
      return (op >= 3'b001) && (op <= 3'b100);
   endfunction

endpackage

// File: rtl/llc_bus_sequencer_bus_rr_arbiter.sv
// rtl/llc_bus_sequencer_bus_rr_arbiter.sv - round-robin pick starting at a pointer
module llc_bus_sequencer_bus_rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   output logic [NUM_REQ-1:0]         grant_o,
   output logic [$clog2(NUM_REQ)-1:0] idx_o,
   output logic                       any_o
);

   localparam int IDW = $clog2(NUM_REQ);

   logic [IDW-1:0] cand;

   // First requester at or after ptr_i, wrapping; earlier hits block later ones.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IDW'((int'(ptr_i) + k) % NUM_REQ);
         if (!any_o && req_i[cand]) begin
            any_o         = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o         = cand;
         end
      end
   end

endmodule

// File: rtl/llc_bus_sequencer.sv
// rtl/llc_bus_sequencer.sv - sequences LLC bus operations from several requesters
module llc_bus_sequencer
   import llc_bus_sequencer_pkg::*;
#(
   parameter int          NUM_REQ       = 4,
   parameter logic [3:0]  CACHE_ID      = 4'h0,
   parameter int          SNOOP_TIMEOUT = 15,
   parameter int          CNT_W         = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [3*NUM_REQ-1:0]       req_op,
   input  logic [32*NUM_REQ-1:0]      req_addr,
   output logic                       bus_valid,
   input  logic                       bus_ready,
   output logic [2:0]                 bus_op,
   output logic [31:0]                bus_addr,
   output logic [3:0]                 bus_cache_id,
   input  logic                       snoop_valid,
   input  logic [1:0]                 snoop_result,
   output logic                       rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic [1:0]                 rsp_result,
   output logic                       rsp_err,
   output logic                       busy,
   output logic [CNT_W-1:0]           rd_count,
   output logic [CNT_W-1:0]           wr_count
);

   localparam int IDW = $clog2(NUM_REQ);

   localparam logic [1:0] S_IDLE  = SEQ_IDLE;
   localparam logic [1:0] S_ISSUE = SEQ_ISSUE;
   localparam logic [1:0] S_WAIT  = SEQ_WAIT_SNOOP;
   localparam logic [1:0] S_RESP  = SEQ_RESP;

   logic [1:0]       state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [31:0]      addr_q, addr_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [7:0]       tmo_q, tmo_d;
   logic [1:0]       res_q, res_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] rd_q, rd_d;
   logic [CNT_W-1:0] wr_q, wr_d;

   logic [NUM_REQ-1:0] grant;
   logic [IDW-1:0]     gnt_idx;
   logic               gnt_any;
   logic [2:0]         sel_op;
   logic [31:0]        sel_addr;
   logic [7:0]         tmo_inc;

   llc_bus_sequencer_bus_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req_i   (req_valid),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .idx_o   (gnt_idx),
      .any_o   (gnt_any)
   );

   // Pull the granted requester's op and address out of the flattened buses.
   always_comb begin
      sel_op   = '0;
      sel_addr = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt_idx == IDW'(k)) begin
            sel_op   = req_op[3*k +: 3];
            sel_addr = req_addr[32*k +: 32];
         end
      end
   end

   assign tmo_inc = tmo_q + 8'd1;

   // Next-state logic: accept, issue, wait for snoop, report.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      tmo_d   = tmo_q;
      res_d   = res_q;
      err_d   = err_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_any) begin
               op_d   = sel_op;
               addr_d = sel_addr;
               id_d   = gnt_idx;
               ptr_d  = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
               if (is_legal_busop(sel_op)) begin
                  state_d = S_ISSUE;
               end else begin
                  state_d = S_RESP;
                  res_d   = SNOOP_NOHIT;
                  err_d   = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (bus_ready) begin
               state_d = S_WAIT;
               tmo_d   = '0;
               if (op_q == BUS_READ || op_q == BUS_RWIM) begin
                  rd_d = (&rd_q) ? rd_q : rd_q + 1'b1;
               end else if (op_q == BUS_WRITE) begin
                  wr_d = (&wr_q) ? wr_q : wr_q + 1'b1;
               end
            end
         end
         S_WAIT: begin
            tmo_d = tmo_inc;
            if (snoop_valid) begin
               state_d = S_RESP;
               if (snoop_result == SNOOP_RESERVED) begin
                  res_d = SNOOP_NOHIT;
                  err_d = 1'b1;
               end else begin
                  res_d = snoop_result;
                  err_d = 1'b0;
               end
            end else if (tmo_inc == 8'(SNOOP_TIMEOUT)) begin
               state_d = S_RESP;
               res_d   = SNOOP_NOHIT;
               err_d   = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         id_q    <= '0;
         ptr_q   <= '0;
         tmo_q   <= '0;
         res_q   <= SNOOP_NOHIT;
         err_q   <= 1'b0;
         rd_q    <= '0;
         wr_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         tmo_q   <= tmo_d;
         res_q   <= res_d;
         err_q   <= err_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

   assign req_ready    = (state_q == S_IDLE) ? grant : '0;
   assign bus_valid    = (state_q == S_ISSUE);
   assign bus_op       = bus_valid ? op_q : 3'b000;
   assign bus_addr     = bus_valid ? addr_q : 32'h0;
   assign bus_cache_id = CACHE_ID;
   assign rsp_valid    = (state_q == S_RESP);
   assign rsp_id       = rsp_valid ? id_q : '0;
   assign rsp_result   = rsp_valid ? res_q : SNOOP_NOHIT;
   assign rsp_err      = rsp_valid & err_q;
   assign busy         = (state_q != S_IDLE);
   assign rd_count     = rd_q;
   assign wr_count     = wr_q;

endmodule

// File: tb/tb_llc_bus_sequencer.sv
// tb/tb_llc_bus_sequencer.sv - directed self-checking bench with a deadline-based reference model
module tb_llc_bus_sequencer;

   localparam int N  = 4;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [3*N-1:0]  req_op;
   logic [32*N-1:0] req_addr;
   logic          bus_valid;
   logic          bus_ready;
   logic [2:0]    bus_op;
   logic [31:0]   bus_addr;
   logic [3:0]    bus_cache_id;
   logic          snoop_valid;
   logic [1:0]    snoop_result;
   logic          rsp_valid;
   logic [1:0]    rsp_id;
   logic [1:0]    rsp_result;
   logic          rsp_err;
   logic          busy;
   logic [31:0]   rd_count;
   logic [31:0]   wr_count;

   llc_bus_sequencer #(
      .NUM_REQ(N), .CACHE_ID(4'h0), .SNOOP_TIMEOUT(TO), .CNT_W(32)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_op(bus_op), .bus_addr(bus_addr),
      .bus_cache_id(bus_cache_id), .snoop_valid(snoop_valid), .snoop_result(snoop_result),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err),
      .busy(busy), .rd_count(rd_count), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int grant_log[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Bus/snoop responder knobs
   int       br_delay  = 0;
   bit       br_always = 0;
   int       sn_delay  = -1;
   logic [1:0] sn_code = 2'b00;

   initial begin : responder
      int st_cnt, sn_cnt;
      bit hs_prev, in_wait;
      bus_ready = 0; snoop_valid = 0; snoop_result = 0;
      st_cnt = 0; sn_cnt = 0; hs_prev = 0; in_wait = 0;
      forever begin
         @(posedge clk); #1;
         snoop_valid = 0;
         if (!rst_n) begin
            in_wait = 0; hs_prev = 0; st_cnt = 0; bus_ready = 0;
         end else begin
            if (hs_prev) begin in_wait = 1; sn_cnt = 0; end
            if (!busy) in_wait = 0;
            if (in_wait) begin
               sn_cnt++;
               if (sn_cnt == sn_delay) begin
                  snoop_valid = 1; snoop_result = sn_code; in_wait = 0;
               end
            end
            if (bus_valid) begin
               if (br_always || st_cnt >= br_delay) begin
                  bus_ready = 1; hs_prev = 1; st_cnt = 0;
               end else begin
                  bus_ready = 0; hs_prev = 0; st_cnt++;
               end
            end else begin
               bus_ready = br_always; hs_prev = 0;
            end
         end
      end
   end

   // Reference model: one transaction with absolute-cycle deadlines
   int  m_ptr = 0, m_acc = 0, m_hs = -1, m_rep = -1, m_id = 0, m_rd = 0, m_wr = 0;
   bit  m_act = 0, m_legal = 0, m_snooped = 0, m_err = 0;
   logic [2:0]  m_op = 0;
   logic [31:0] m_addr = 0;
   logic [1:0]  m_res = 0;

   always @(negedge clk) begin : model
      int pick, j;
      logic [N-1:0] exp_ready;
      bit exp_bv, exp_rv;
      if (!rst_n) begin
         check("reset_outputs", {req_ready, bus_valid, bus_op, bus_addr, rsp_valid, rsp_id,
                                 rsp_result, rsp_err, busy}, 64'h0);
         check("reset_rd_count", rd_count, 0);
         check("reset_wr_count", wr_count, 0);
         m_act = 0; m_ptr = 0; m_rd = 0; m_wr = 0;
      end else begin
         pick = -1;
         if (!m_act) begin
            for (int k = 0; k < N; k++) begin
               j = (m_ptr + k) % N;
               if (pick < 0 && ((req_valid >> j) & 4'b1) != 0) pick = j;
            end
         end
         exp_ready = (pick >= 0) ? (4'b1 << pick) : 4'b0;
         exp_bv = m_act && m_legal && (cyc > m_acc) && (m_hs < 0);
         exp_rv = m_act && (cyc == m_rep);
         check("req_ready", req_ready, exp_ready);
         check("req_ready_onehot", ($countones(req_ready) <= 1), 1);
         check("bus_valid", bus_valid, exp_bv);
         check("bus_op", bus_op, exp_bv ? m_op : 3'b0);
         check("bus_addr", bus_addr, exp_bv ? m_addr : 32'h0);
         check("bus_cache_id", bus_cache_id, 4'h0);
         check("rsp_valid", rsp_valid, exp_rv);
         check("rsp_id", rsp_id, exp_rv ? m_id : 0);
         check("rsp_result", rsp_result, exp_rv ? m_res : 2'b0);
         check("rsp_err", rsp_err, exp_rv ? m_err : 1'b0);
         check("busy", busy, m_act);
         check("rd_count", rd_count, m_rd);
         check("wr_count", wr_count, m_wr);
         if (exp_bv && bus_ready) begin
            m_hs = cyc; m_rep = cyc + 1 + TO; m_res = 2'b00; m_err = 1;
            if (m_op == 3'd1 || m_op == 3'd4) m_rd++;
            else if (m_op == 3'd2) m_wr++;
         end else if (m_act && m_hs >= 0 && cyc > m_hs && cyc < m_rep && !m_snooped && snoop_valid) begin
            m_snooped = 1; m_rep = cyc + 1;
            m_res = (snoop_result == 2'b11) ? 2'b00 : snoop_result;
            m_err = (snoop_result == 2'b11);
         end
         if (exp_rv) m_act = 0;
         if (pick >= 0) begin
            m_act = 1; m_acc = cyc; m_id = pick; m_ptr = (pick + 1) % N;
            m_op = 3'(req_op >> (3 * pick));
            m_addr = 32'(req_addr >> (32 * pick));
            m_legal = (m_op >= 3'd1 && m_op <= 3'd4);
            m_hs = -1; m_snooped = 0;
            if (!m_legal) begin m_rep = cyc + 1; m_res = 2'b00; m_err = 1; end
            else m_rep = -1;
            grant_log.push_back(pick);
         end
      end
   end

   task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a);
      req_op   = (req_op & ~(12'h7 << (3 * i))) | (12'(op) << (3 * i));
      req_addr = (req_addr & ~({96'h0, 32'hFFFF_FFFF} << (32 * i))) | (128'(a) << (32 * i));
   endtask

   task automatic issue(input int i, input logic [2:0] op, input logic [31:0] a, output int acc);
      bit got;
      got = 0; acc = -1;
      set_req(i, op, a);
      req_valid = req_valid | (4'b1 << i);
      for (int k = 0; k < 50 && !got; k++) begin
         #1;
         if (((req_ready >> i) & 4'b1) != 0) begin got = 1; acc = cyc; end
         @(posedge clk); #1;
      end
      req_valid = req_valid & ~(4'b1 << i);
      if (!got) check("issue_timeout", 0, 1);
   endtask

   task automatic wait_rsp(output int rc, output int id, output int res, output int err);
      bit got;
      got = 0; rc = -1; id = -1; res = -1; err = -1;
      for (int k = 0; k < 80 && !got; k++) begin
         if (rsp_valid) begin got = 1; rc = cyc; id = rsp_id; res = rsp_result; err = rsp_err; end
         @(posedge clk); #1;
      end
      if (!got) check("rsp_timeout", 0, 1);
   endtask

   task automatic do_reset();
      rst_n = 0; req_valid = 0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1;
   endtask

   initial begin : stim
      int a, r, id, res, err, n0;
      bit got;
      rst_n = 0; req_valid = 0; req_op = 0; req_addr = 0;
      repeat (3) @(posedge clk);
      #1; rst_n = 1;

      // 1: single READ, HIT two cycles after handshake
      sn_delay = 2; sn_code = 2'b01;
      issue(1, 3'b001, 32'h0000_1000, a);
      check("t1_bus_valid_T1", bus_valid, 1);
      check("t1_bus_addr", bus_addr, 32'h0000_1000);
      wait_rsp(r, id, res, err);
      check("t1_rsp_cycle", r, a + 4);
      check("t1_rsp_id", id, 1);
      check("t1_rsp_result", res, 1);
      check("t1_rsp_err", err, 0);
      check("t1_rd_count", rd_count, 1);

      // 2: all requesters held high, round-robin order
      do_reset();
      grant_log.delete();
      br_always = 1; sn_delay = 1; sn_code = 2'b00;
      for (int i = 0; i < N; i++) set_req(i, 3'b001, 32'h100 * i);
      req_valid = 4'hF;
      got = 0;
      for (int k = 0; k < 200 && !got; k++) begin
         if (grant_log.size() >= 5) got = 1;
         else begin @(posedge clk); #1; end
      end
      req_valid = 0;
      if (!got) check("t2_grant_timeout", 0, 1);
      wait_rsp(r, id, res, err);
      br_always = 0;
      if (grant_log.size() >= 5) begin
         check("t2_grant0", grant_log[0], 0);
         check("t2_grant1", grant_log[1], 1);
         check("t2_grant2", grant_log[2], 2);
         check("t2_grant3", grant_log[3], 3);
         check("t2_grant4", grant_log[4], 0);
      end

      // 3: WRITE with no snoop -> timeout; then snoop on the expiry cycle wins
      do_reset();
      sn_delay = -1;
      issue(0, 3'b010, 32'h0000_2040, a);
      wait_rsp(r, id, res, err);
      check("t3_rsp_cycle", r, a + 17);
      check("t3_rsp_result", res, 0);
      check("t3_rsp_err", err, 1);
      check("t3_wr_count", wr_count, 1);
      sn_delay = 15; sn_code = 2'b01;
      issue(1, 3'b001, 32'h0000_2080, a);
      wait_rsp(r, id, res, err);
      check("t3b_rsp_cycle", r, a + 17);
      check("t3b_rsp_result", res, 1);
      check("t3b_rsp_err", err, 0);
      check("t3b_rd_count", rd_count, 1);

      // 4: RWIM, WRITE, INVALIDATE with stalled bus_ready
      do_reset();
      br_delay = 3; sn_delay = 1; sn_code = 2'b01;
      issue(0, 3'b100, 32'h0000_3000, a);
      wait_rsp(r, id, res, err);
      check("t4_rwim_rsp_cycle", r, a + 6);
      issue(1, 3'b010, 32'h0000_3040, a);
      wait_rsp(r, id, res, err);
      sn_code = 2'b11;
      issue(2, 3'b011, 32'h0000_3080, a);
      wait_rsp(r, id, res, err);
      check("t4_reserved_result", res, 0);
      check("t4_reserved_err", err, 1);
      check("t4_rd_count", rd_count, 1);
      check("t4_wr_count", wr_count, 1);
      br_delay = 0;

      // 5: illegal op on req 2, then req 0 and 3 together -> 3 first
      do_reset();
      sn_delay = 1; sn_code = 2'b00;
      issue(2, 3'b111, 32'hDEAD_0000, a);
      wait_rsp(r, id, res, err);
      check("t5_rsp_cycle", r, a + 1);
      check("t5_rsp_id", id, 2);
      check("t5_rsp_err", err, 1);
      n0 = grant_log.size();
      set_req(0, 3'b001, 32'h0000_5000);
      set_req(3, 3'b001, 32'h0000_5300);
      req_valid = 4'b1001;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         if (grant_log.size() > n0) got = 1;
         else begin @(posedge clk); #1; end
      end
      req_valid = 0;
      if (got) check("t5_next_grant", grant_log[n0], 3);
      else check("t5_grant_timeout", 0, 1);
      wait_rsp(r, id, res, err);

      // 6: reset during WAIT_SNOOP, then a clean READ with HITM
      do_reset();
      sn_delay = -1;
      issue(0, 3'b001, 32'h0000_4000, a);
      repeat (3) begin @(posedge clk); #1; end
      check("t6_busy_before_reset", busy, 1);
      rst_n = 0;
      #1;
      check("t6_outputs_in_reset", {req_ready, bus_valid, bus_op, bus_addr, rsp_valid, rsp_err, busy}, 64'h0);
      check("t6_rd_in_reset", rd_count, 0);
      @(posedge clk); #1;
      rst_n = 1;
      sn_delay = 1; sn_code = 2'b10;
      issue(0, 3'b001, 32'h0000_4040, a);
      wait_rsp(r, id, res, err);
      check("t6_rsp_id", id, 0);
      check("t6_rsp_result", res, 2);
      check("t6_rsp_err", err, 0);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
